// File: rtl/conv_alu_pkg.sv
// Shared opcode, state and flag definitions for the conv_alu execute block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD     = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB     = 3'b001;
    localparam logic [OP_W-1:0] OP_AND     = 3'b010;
    localparam logic [OP_W-1:0] OP_OR      = 3'b011;
    localparam logic [OP_W-1:0] OP_CONVACC = 3'b100;
    localparam logic [OP_W-1:0] OP_SLT     = 3'b101;
    localparam logic [OP_W-1:0] OP_ACCRD   = 3'b110;
    localparam logic [OP_W-1:0] OP_CONV    = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Condition flags kept together so they are captured with the result.
    typedef struct packed {
        logic ovf;
        logic carry;
        logic zero;
        logic neg;
    } flags_t;

    // True for the opcodes that run the multi-cycle dot-product engine.
    function automatic logic is_conv_op(input logic [OP_W-1:0] op);
        return (op == OP_CONV) || (op == OP_CONVACC);
    endfunction

endpackage

// File: rtl/conv_alu_if.sv
// Request/response bundle between the EX-stage sequencer and conv_alu.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface conv_alu_if #(
    parameter int WIDTH = 32
);
    import conv_alu_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [OP_W-1:0]      ALUControl;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     Result;
    logic                 OverFlow;
    logic                 Carry;
    logic                 Zero;
    logic                 Negative;

    modport master (
        output in_valid, A, B, ALUControl, out_ready,
        input  in_ready, out_valid, Result, OverFlow, Carry, Zero, Negative
    );

    modport slave (
        input  in_valid, A, B, ALUControl, out_ready,
        output in_ready, out_valid, Result, OverFlow, Carry, Zero, Negative
    );

endinterface

// File: rtl/conv_alu_mac_lane.sv
// One multiply-accumulate step: acc_out = acc_in + sign-extended (a * b).
// Latency: combinational.
// Backpressure: none.
module mac_lane #(
    parameter int ELEM_W = 8,
    parameter int WIDTH  = 32
) (
    input  logic signed [ELEM_W-1:0] a,
    input  logic signed [ELEM_W-1:0] b,
    input  logic        [WIDTH-1:0]  acc_in,
    output logic        [WIDTH-1:0]  acc_out
);

    localparam int PROD_W = 2 * ELEM_W;

    logic [PROD_W-1:0] prod;
    logic [WIDTH-1:0]  prod_ext;

    // Operands are sign-extended up front so the low PROD_W bits of an
    // unsigned multiply equal the signed product.
    assign prod = {{ELEM_W{a[ELEM_W-1]}}, a} * {{ELEM_W{b[ELEM_W-1]}}, b};

    generate
        if (PROD_W >= WIDTH) begin : g_trunc
            assign prod_ext = prod[WIDTH-1:0];
        end else begin : g_sext
            assign prod_ext = {{(WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
        end
    endgenerate

    assign acc_out = acc_in + prod_ext;

endmodule

// File: rtl/conv_alu.sv
// EX-stage ALU with a sequential packed dot-product engine and a persistent accumulator.
// Latency: ALU ops and ACCRD 1 cycle; CONV/CONVACC N_ELEM+1 cycles.
// Backpressure: in_ready only in IDLE; result held in HOLD until out_ready.
module conv_alu
    import conv_alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ELEM_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    conv_alu_if.slave bus
);

    localparam int N_ELEM = WIDTH / ELEM_W;
    localparam int IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   a_sh_q,    a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,    b_sh_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [WIDTH-1:0]   partial_q, partial_d;
    logic [WIDTH-1:0]   acc_q,     acc_d;
    logic [WIDTH-1:0]   result_q,  result_d;
    flags_t             flags_q,   flags_d;

    logic               load_res;
    logic [WIDTH-1:0]   mac_sum;

    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;

    // The lowest element of each shift register feeds the lane every MAC cycle.
    mac_lane #(
        .ELEM_W (ELEM_W),
        .WIDTH  (WIDTH)
    ) u_mac_lane (
        .a       (a_sh_q[ELEM_W-1:0]),
        .b       (b_sh_q[ELEM_W-1:0]),
        .acc_in  (partial_q),
        .acc_out (mac_sum)
    );

    assign add_w = {1'b0, bus.A} + {1'b0, bus.B};
    assign sub_w = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};

    // Single-cycle ALU datapath on the live operands; only used at acceptance.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (bus.ALUControl)
            OP_ADD: begin
                alu_res   = add_w[WIDTH-1:0];
                alu_carry = add_w[WIDTH];
                alu_ovf   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                            (add_w[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = sub_w[WIDTH-1:0];
                alu_carry = sub_w[WIDTH];
                alu_ovf   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                            (sub_w[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND: alu_res = bus.A & bus.B;
            OP_OR:  alu_res = bus.A | bus.B;
            // Raw sign of the difference, deliberately without overflow correction.
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, sub_w[WIDTH-1]};
            default: alu_res = '0;
        endcase
    end

    // Next-state logic for the IDLE/MAC/HOLD sequencer and all datapath registers.
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        idx_d     = idx_q;
        partial_d = partial_q;
        acc_d     = acc_q;
        result_d  = result_q;
        flags_d   = flags_q;
        load_res  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (is_conv_op(bus.ALUControl)) begin
                        a_sh_d    = bus.A;
                        b_sh_d    = bus.B;
                        idx_d     = '0;
                        partial_d = (bus.ALUControl == OP_CONVACC) ? acc_q : '0;
                        state_d   = MAC;
                    end else if (bus.ALUControl == OP_ACCRD) begin
                        result_d      = acc_q;
                        flags_d.carry = 1'b0;
                        flags_d.ovf   = 1'b0;
                        acc_d         = '0;
                        load_res      = 1'b1;
                        state_d       = HOLD;
                    end else begin
                        result_d      = alu_res;
                        flags_d.carry = alu_carry;
                        flags_d.ovf   = alu_ovf;
                        load_res      = 1'b1;
                        state_d       = HOLD;
                    end
                end
            end
            MAC: begin
                partial_d = mac_sum;
                a_sh_d    = a_sh_q >> ELEM_W;
                b_sh_d    = b_sh_q >> ELEM_W;
                idx_d     = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    result_d      = mac_sum;
                    acc_d         = mac_sum;
                    flags_d.carry = 1'b0;
                    flags_d.ovf   = 1'b0;
                    load_res      = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Zero and Negative always follow whatever result is being captured.
        if (load_res) begin
            flags_d.zero = (result_d == '0);
            flags_d.neg  = result_d[WIDTH-1];
        end
    end

    // State and datapath registers; reset discards any in-flight dot product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            idx_q     <= '0;
            partial_q <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            idx_q     <= idx_d;
            partial_q <= partial_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.Result    = result_q;
    assign bus.OverFlow  = flags_q.ovf;
    assign bus.Carry     = flags_q.carry;
    assign bus.Zero      = flags_q.zero;
    assign bus.Negative  = flags_q.neg;

endmodule

// File: tb/tb_conv_alu.sv
// Directed scoreboard bench for conv_alu with default parameters.
// Latency: checks 1-cycle ALU/ACCRD and 5-cycle conv result timing.
// Backpressure: exercises out_ready held low and mid-conv reset.
module tb_conv_alu;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;   // {ovf, carry, zero, neg}
        int          lat;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_acc = '0;

    conv_alu_if #(.WIDTH(32)) bus ();

    conv_alu #(.WIDTH(32), .ELEM_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dot(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       s;
        logic signed [7:0] ea;
        logic signed [7:0] eb;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            ea = a[8*i +: 8];
            eb = b[8*i +: 8];
            s  = s + 32'(int'(ea) * int'(eb));
        end
        return s;
    endfunction

    // Reference behaviour; also advances the bench's own accumulator.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input string tag);
        exp_t    e;
        longint  sa, sbv, s;
        longint unsigned ua, ub;
        logic [31:0] r;
        logic    ovf, cy;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'(a) & 64'hFFFF_FFFF;
        ub  = longint'(b) & 64'hFFFF_FFFF;
        r = '0; ovf = 1'b0; cy = 1'b0; e.lat = 1;
        case (op)
            3'b000: begin
                r = a + b; s = sa + sbv;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                cy  = ((ua + ub) >> 32) != 0;
            end
            3'b001: begin
                r = a - b; s = sa - sbv;
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                cy  = (ua >= ub);
            end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b101: begin r = a - b; r = {31'b0, r[31]}; end
            3'b111: begin r = dot(a, b); model_acc = r; e.lat = 5; end
            3'b100: begin r = model_acc + dot(a, b); model_acc = r; e.lat = 5; end
            3'b110: begin r = model_acc; model_acc = '0; end
            default: r = '0;
        endcase
        e.res = r;
        e.flg = {ovf, cy, (r == 32'd0), r[31]};
        e.tag = tag;
        return e;
    endfunction

    // Present one op at a negedge; returns at the first negedge after acceptance.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_in_ready_timeout"}, 32'(n >= 50), 32'd0);
        bus.in_valid   = 1'b1;
        bus.A          = a;
        bus.B          = b;
        bus.ALUControl = op;
        sb.push_back(model(op, a, b, tag));
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.A          = $urandom();
        bus.B          = $urandom();
        bus.ALUControl = 3'($urandom());
    endtask

    // Wait for the result, compare it, optionally stall, then consume it.
    task automatic collect(input int hold);
        exp_t e;
        int   lat;
        logic rdy_seen;
        logic unstable;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        lat = 1; rdy_seen = 1'b0; unstable = 1'b0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk({e.tag, "_latency"}, 32'(lat), 32'(e.lat));
        chk({e.tag, "_busy_in_ready"}, {31'b0, rdy_seen | bus.in_ready}, 32'd0);
        chk({e.tag, "_result"}, bus.Result, e.res);
        chk({e.tag, "_flags"}, {28'b0, bus.OverFlow, bus.Carry, bus.Zero, bus.Negative},
            {28'b0, e.flg});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.Result !== e.res || !bus.out_valid || bus.in_ready ||
                {bus.OverFlow, bus.Carry, bus.Zero, bus.Negative} !== e.flg)
                unstable = 1'b1;
        end
        if (hold > 0) chk({e.tag, "_hold_stable"}, {31'b0, unstable}, 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({e.tag, "_released"}, {30'b0, bus.in_ready, bus.out_valid}, 32'b10);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        send(op, a, b, tag);
        collect(0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.A          = '0;
        bus.B          = '0;
        bus.ALUControl = '0;
        repeat (2) @(negedge clk);
        chk("reset_handshake", {30'b0, bus.in_ready, bus.out_valid}, 32'b10);
        chk("reset_result", bus.Result, 32'd0);
        chk("reset_flags", {28'b0, bus.OverFlow, bus.Carry, bus.Zero, bus.Negative}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, "add_ovf");
        do_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, "add_carry");
        do_op(3'b001, 32'd5, 32'd5, "sub_zero");
        do_op(3'b001, 32'h8000_0000, 32'd1, "sub_ovf");
        do_op(3'b101, 32'd3, 32'd7, "slt_lt");
        do_op(3'b101, 32'd7, 32'd3, "slt_ge");
        do_op(3'b010, 32'hF0F0_1234, 32'h0FF0_FF00, "and");
        do_op(3'b011, 32'hF000_0000, 32'h0000_000F, "or");

        do_op(3'b111, 32'hFF02_0304, 32'h0202_0202, "conv_16");
        do_op(3'b110, 32'hDEAD_BEEF, 32'h1234_5678, "accrd_16");
        do_op(3'b111, 32'h0101_0101, 32'h0101_0101, "conv_4");
        do_op(3'b100, 32'h0101_0101, 32'h0101_0101, "convacc_8");
        do_op(3'b110, 32'd0, 32'd0, "accrd_8");
        do_op(3'b110, 32'd0, 32'd0, "accrd_empty");

        // Negative dot product, then ALU ops must leave the accumulator alone.
        do_op(3'b111, 32'h8080_8080, 32'h7F7F_7F7F, "conv_neg");
        do_op(3'b000, 32'd10, 32'd20, "add_between");
        do_op(3'b011, 32'd1, 32'd2, "or_between");
        do_op(3'b110, 32'd0, 32'd0, "accrd_neg");

        // Consumer stalls for 10 cycles on a conv result.
        send(3'b111, 32'h7F7F_7F7F, 32'h7F7F_7F7F, "conv_bp");
        collect(10);
        do_op(3'b110, 32'd0, 32'd0, "accrd_bp");

        // Reset in the middle of a conv wipes partial sum and accumulator.
        do_op(3'b111, 32'h0101_0101, 32'h0101_0101, "conv_pre_rst");
        send(3'b111, 32'h0505_0505, 32'h0303_0303, "conv_rst");
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_mac_reset", {30'b0, bus.in_ready, bus.out_valid}, 32'b10);
        model_acc = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(3'b110, 32'd0, 32'd0, "accrd_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
